// File: rtl/vpp_meter_if.sv
// vpp_meter_if: groups the measurement enable, the peak pair from the cycle
// FIFO stage and the averaged results of the peak-to-peak meter.
//   en       measurement enable (level)
//   max_in   peak maximum, 8 bits
//   min_in   peak minimum, 8 bits
//   vpp      averaged max-min, 8 bits
//   vpp_bcd  vpp as 3-digit BCD, hundreds in [11:8]
//   mid      averaged midpoint (zero unless VPP_METER_OFFSET_EN is defined)
//   valid    one-cycle pulse when the results update
//   err      a sample was discarded in the batch behind the results
// master: the side that drives enable/peaks and reads results (testbench).
// slave:  the meter itself.
interface vpp_meter_if;
  logic        en;
  logic [7:0]  max_in;
  logic [7:0]  min_in;
  logic [7:0]  vpp;
  logic [11:0] vpp_bcd;
  logic [7:0]  mid;
  logic        valid;
  logic        err;

  modport master (
    output en, max_in, min_in,
    input  vpp, vpp_bcd, mid, valid, err
  );

  modport slave (
    input  en, max_in, min_in,
    output vpp, vpp_bcd, mid, valid, err
  );
endinterface

// File: rtl/vpp_meter.sv
// vpp_meter: periodically samples the max/min peak pair, averages
// 2^AVG_LOG2 peak-to-peak readings, converts the average to 3-digit BCD
// and flags batches in which a sample had min > max.
// Parameters:
//   SAMPLE_DIV  cycles spent waiting between samples (>= 2)
//   AVG_LOG2    log2 of samples per averaged result (1..6)
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   vpp_meter_if.slave (en, max_in, min_in in; vpp, vpp_bcd, mid,
//         valid, err out; all outputs registered)
// Build option:
//   VPP_METER_OFFSET_EN  when defined, the midpoint accumulator is built
//                        and mid carries the averaged (max+min)/2;
//                        otherwise mid is held at zero.
module vpp_meter #(
  parameter int SAMPLE_DIV = 1000000,
  parameter int AVG_LOG2   = 3
) (
  input  logic      clk,
  input  logic      rst,
  vpp_meter_if.slave bus
);

  localparam int TW    = $clog2(SAMPLE_DIV);
  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int N_W   = AVG_LOG2 + 1;
  localparam logic [TW-1:0]  TIMER_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [N_W-1:0] N_LAST     = N_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SAMPLE = 3'd2,
    AVG    = 3'd3,
    CONV   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_r;
  logic [TW-1:0]    timer_r;
  logic [ACC_W-1:0] acc_r;
  logic [N_W-1:0]   n_r;
  logic             disc_r;
  logic [7:0]       vpp_avg_r;
  logic [19:0]      dd_r;      // {hundreds, tens, units, binary}
  logic [2:0]       cnt_r;
  logic [7:0]       vpp_r;
  logic [11:0]      bcd_r;
  logic             valid_r;
  logic             err_r;
  logic [19:0]      dd_next_s;

`ifdef VPP_METER_OFFSET_EN
  logic [ACC_W:0]   macc_r;
  logic [7:0]       mid_avg_r;
  logic [7:0]       mid_r;
`endif

  // One double-dabble step: correct each BCD digit >= 5, then shift left.
  // The hundreds digit never exceeds 2 for an 8-bit input, so it cannot carry out.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5) begin
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
      end
    end
    return {t[18:0], 1'b0};
  endfunction

  assign dd_next_s = dd_step(dd_r);

  // Measurement sequencer: sampling, accumulation, averaging, BCD conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      acc_r     <= '0;
      n_r       <= '0;
      disc_r    <= 1'b0;
      vpp_avg_r <= 8'd0;
      dd_r      <= 20'd0;
      cnt_r     <= 3'd0;
      vpp_r     <= 8'd0;
      bcd_r     <= 12'd0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
`ifdef VPP_METER_OFFSET_EN
      macc_r    <= '0;
      mid_avg_r <= 8'd0;
      mid_r     <= 8'd0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // Clearing here also discards any batch abandoned by en=0.
          timer_r <= '0;
          acc_r   <= '0;
          n_r     <= '0;
          disc_r  <= 1'b0;
`ifdef VPP_METER_OFFSET_EN
          macc_r  <= '0;
`endif
          state_r <= bus.en ? WAIT : IDLE;
        end
        WAIT: begin
          if (!bus.en) begin
            state_r <= IDLE;
          end else if (timer_r == TIMER_LAST) begin
            timer_r <= '0;
            state_r <= SAMPLE;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        SAMPLE: begin
          timer_r <= '0;
          if (bus.max_in >= bus.min_in) begin
            acc_r   <= acc_r + ACC_W'(bus.max_in - bus.min_in);
`ifdef VPP_METER_OFFSET_EN
            macc_r  <= macc_r + (ACC_W + 1)'({1'b0, bus.max_in} + {1'b0, bus.min_in});
`endif
            n_r     <= n_r + 1'b1;
            state_r <= (n_r == N_LAST) ? AVG : WAIT;
          end else begin
            disc_r  <= 1'b1;
            state_r <= WAIT;
          end
        end
        AVG: begin
          // Truncating divide by 2^AVG_LOG2 is a plain bit selection.
          vpp_avg_r <= acc_r[AVG_LOG2 +: 8];
          dd_r      <= {12'd0, acc_r[AVG_LOG2 +: 8]};
`ifdef VPP_METER_OFFSET_EN
          mid_avg_r <= macc_r[AVG_LOG2 + 1 +: 8];
`endif
          cnt_r     <= 3'd0;
          state_r   <= CONV;
        end
        CONV: begin
          dd_r  <= dd_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            // Results are loaded on the final shift so they are visible in DONE.
            vpp_r   <= vpp_avg_r;
            bcd_r   <= dd_next_s[19:8];
            err_r   <= disc_r;
`ifdef VPP_METER_OFFSET_EN
            mid_r   <= mid_avg_r;
`endif
            valid_r <= 1'b1;
            state_r <= DONE;
          end
        end
        DONE: begin
          acc_r   <= '0;
          n_r     <= '0;
          disc_r  <= 1'b0;
          timer_r <= '0;
`ifdef VPP_METER_OFFSET_EN
          macc_r  <= '0;
`endif
          state_r <= bus.en ? WAIT : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.vpp     = vpp_r;
  assign bus.vpp_bcd = bcd_r;
  assign bus.valid   = valid_r;
  assign bus.err     = err_r;
`ifdef VPP_METER_OFFSET_EN
  assign bus.mid     = mid_r;
`else
  assign bus.mid     = 8'd0;
`endif

endmodule

// File: tb/tb_vpp_meter.sv
// tb_vpp_meter: randomized and directed stimulus for vpp_meter, checked
// against a batch-level reference model (sums, integer division, decimal
// digits and the sample-schedule arithmetic).
module tb_vpp_meter;
  localparam int SD  = 4;
  localparam int AL  = 2;
  localparam int NS  = 1 << AL;
  localparam int PER = SD + 1;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  vpp_meter_if bus();

  vpp_meter #(.SAMPLE_DIV(SD), .AVG_LOG2(AL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mid_of(input int v);
`ifdef VPP_METER_OFFSET_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Peak pair for sample j (1-based) of a batch in the given mode.
  task automatic gen_pair(input int mode, input int j, output logic [7:0] mx, output logic [7:0] mn);
    logic [7:0] t;
    case (mode)
      1: begin mx = 8'd200; mn = 8'd50; end
      2: begin mx = 8'(9 + j); mn = 8'd0; end
      3: begin mx = 8'd255; mn = 8'd0; end
      4: begin
        if (j == 2) begin mx = 8'd10; mn = 8'd20; end
        else begin mx = 8'd100; mn = 8'd0; end
      end
      5: begin mx = 8'd250; mn = 8'd0; end
      default: begin
        mx = 8'($urandom_range(255, 0));
        mn = 8'($urandom_range(255, 0));
        if (mn > mx && ($urandom_range(3, 0) != 0 || j > 12)) begin
          t = mx; mx = mn; mn = t;
        end
      end
    endcase
  endtask

  // Called at a negedge in the cycle just before the first WAIT cycle
  // (IDLE with en=1, or DONE with en=1). abort_at>0 drops en after that many
  // samples; rst_conv asserts reset in the middle of the conversion.
  task automatic run_batch(input int mode, input int abort_at, input bit rst_conv, output int vcyc);
    int good, j, vexp, sum_d, sum_s, ev, em, eb;
    bit any_bad, seen, stopped;
    logic [7:0] mx, mn;
    good = 0; j = 1; vexp = -1; sum_d = 0; sum_s = 0;
    any_bad = 1'b0; seen = 1'b0; stopped = 1'b0; vcyc = -1;
    gen_pair(mode, j, mx, mn);
    bus.max_in = mx; bus.min_in = mn;
    if (mx >= mn) begin good++; sum_d += mx - mn; sum_s += mx + mn; end
    else any_bad = 1'b1;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      check_eq("valid", {31'd0, bus.valid}, (c == vexp) ? 32'd1 : 32'd0);
      if (c == vexp) begin
        ev = sum_d / NS;
        em = mid_of(sum_s / (2 * NS));
        eb = ((ev / 100) << 8) | (((ev / 10) % 10) << 4) | (ev % 10);
        check_eq("vpp", bus.vpp, ev);
        check_eq("vpp_bcd", bus.vpp_bcd, eb);
        check_eq("mid", bus.mid, em);
        check_eq("err", bus.err, any_bad ? 32'd1 : 32'd0);
        seen = 1'b1; vcyc = c;
        break;
      end
      if (abort_at > 0 && c == abort_at * PER + 1) begin
        bus.en = 1'b0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          check_eq("valid_abort", {31'd0, bus.valid}, 32'd0);
        end
        stopped = 1'b1;
        break;
      end
      if (rst_conv && c == vexp - 5) begin
        rst = 1'b1; bus.en = 1'b0;
        stopped = 1'b1;
        break;
      end
      if (vexp < 0 && c > PER && c % PER == 1) begin
        j++;
        gen_pair(mode, j, mx, mn);
        bus.max_in = mx; bus.min_in = mn;
        if (mx >= mn) begin good++; sum_d += mx - mn; sum_s += mx + mn; end
        else any_bad = 1'b1;
      end
      if (vexp < 0 && good == NS) vexp = j * PER + 10;
    end
    if (!stopped) check_eq("batch_seen", {31'd0, seen}, 32'd1);
  endtask

  int vc;

  initial begin
    rst = 1'b1; bus.en = 1'b1; bus.max_in = 8'd0; bus.min_in = 8'd0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_vpp", bus.vpp, 32'd0);
      check_eq("rst_bcd", bus.vpp_bcd, 32'd0);
      check_eq("rst_mid", bus.mid, 32'd0);
      check_eq("rst_valid", {31'd0, bus.valid}, 32'd0);
      check_eq("rst_err", {31'd0, bus.err}, 32'd0);
    end
    rst = 1'b0;

    run_batch(1, 0, 1'b0, vc);
    check_eq("c150_gap", vc, 32'd30);
    check_eq("c150_vpp", bus.vpp, 32'd150);
    check_eq("c150_bcd", bus.vpp_bcd, 32'h150);
    check_eq("c150_mid", bus.mid, mid_of(125));

    run_batch(2, 0, 1'b0, vc);
    check_eq("ramp_vpp", bus.vpp, 32'd11);
    check_eq("ramp_bcd", bus.vpp_bcd, 32'h011);

    run_batch(3, 0, 1'b0, vc);
    check_eq("full_vpp", bus.vpp, 32'd255);
    check_eq("full_bcd", bus.vpp_bcd, 32'h255);
    check_eq("full_mid", bus.mid, mid_of(127));

    run_batch(4, 0, 1'b0, vc);
    check_eq("drop_gap", vc, 32'd35);
    check_eq("drop_vpp", bus.vpp, 32'd100);
    check_eq("drop_err", {31'd0, bus.err}, 32'd1);

    run_batch(1, 0, 1'b0, vc);
    check_eq("clean_err", {31'd0, bus.err}, 32'd0);

    // Abandon a batch of 250/0 samples, then a fresh ramp batch must ignore them.
    run_batch(5, 2, 1'b0, vc);
    bus.en = 1'b1;
    run_batch(2, 0, 1'b0, vc);
    check_eq("fresh_gap", vc, 32'd30);
    check_eq("fresh_vpp", bus.vpp, 32'd11);

    repeat (6) run_batch(0, 0, 1'b0, vc);

    // Reset in the middle of the BCD conversion.
    run_batch(3, 0, 1'b1, vc);
    @(negedge clk);
    check_eq("rc_vpp", bus.vpp, 32'd0);
    check_eq("rc_bcd", bus.vpp_bcd, 32'd0);
    check_eq("rc_mid", bus.mid, 32'd0);
    check_eq("rc_err", {31'd0, bus.err}, 32'd0);
    check_eq("rc_valid", {31'd0, bus.valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      check_eq("rc_quiet", {31'd0, bus.valid}, 32'd0);
    end
    bus.en = 1'b1;
    run_batch(0, 0, 1'b0, vc);
    run_batch(0, 0, 1'b0, vc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
